dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sits between the two CPU cores' MEM stages and the shared dual-port data memory.
- Forwards each core's load/store to its own memory port.
- Detects same-word conflicts (at least one side writing) and serializes them, stalling the losing core with round-robin fairness.
- Blocks illegal accesses (misaligned or out of range) and flags them.

Parameters:
- MEM_BYTES, 128, data memory size in bytes; legal word addresses are 0 to MEM_BYTES-4.
- CNT_W, 16, width of the conflict counter (optional feature only).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- c1_addr_i  in  32  core1 byte address.
- c1_data_i  in  32  core1 store data.
- c1_MemRead_i  in  1  core1 load request.
- c1_MemWrite_i  in  1  core1 store request.
- c1_data_o  out  32  core1 load data.
- c1_stall_o  out  1  core1 must hold its request and freeze its pipeline.
- c2_addr_i, c2_data_i, c2_MemRead_i, c2_MemWrite_i, c2_data_o, c2_stall_o  same as core1, for core2.
- m_addr_o1, m_data_o1  out  32 each  to memory port 1.
- m_MemRead_o1, m_MemWrite_o1  out  1 each  to memory port 1.
- m_data_i1  in  32  read data from memory port 1.
- m_addr_o2, m_data_o2, m_MemRead_o2, m_MemWrite_o2, m_data_i2  same, for memory port 2.
- err_o  out  2  sticky illegal-access flags; bit0 = core1, bit1 = core2.

Behaviour:
- Address and data pass through combinationally: m_addr_oN = cN_addr_i, m_data_oN = cN_data_i, cN_data_o = m_data_iN.
- Request is active when cN_MemRead_i | cN_MemWrite_i.
- Illegal access: addr[1:0] != 0, or addr > MEM_BYTES-4.
  - The request is masked: m_MemRead/m_MemWrite for that port = 0, no stall.
  - err_o[N] sets at the next rising edge and stays set until reset.
- Conflict: both requests active and legal, c1_addr_i[31:2] == c2_addr_i[31:2], and at least one MemWrite. Read/read to the same word is not a conflict.
- State: 1-bit prio register (0 = core1 favoured); reset value 0.
- No conflict: both stalls 0, both memory enables follow the requests; prio unchanged.
- Conflict, winner = prio:
  - Winner's memory enables follow its request.
  - Loser: stall_o = 1, its memory MemRead/MemWrite forced to 0.
  - At the rising edge, prio is set to the loser's index.
- Persistent conflict (winner reissues to the same word next cycle): the previous loser now wins. Strict alternation; no starvation; maximum stall is 1 cycle per conflict.
- Simultaneous conflict and illegal access cannot occur, because legality is checked first.
- Both MemRead and MemWrite asserted by one core is treated as a write.
- Reset asserted (rst_i = 0), asynchronous and mid-operation:
  - prio = 0 and err_o = 0 immediately.
  - Both stall_o = 1 and all m_MemRead/m_MemWrite = 0 while reset is held.
  - Normal operation resumes on the first edge after release.
- Latency: zero added cycles when there is no conflict; +1 cycle for the loser of each conflict.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt_o [CNT_W-1:0], reset 0.
  - Increments by 1 on every rising edge where a conflict is present; saturates at all-ones (no wrap).
  - Adds output stall_cyc_o [CNT_W-1:0], counting cycles in which either stall_o = 1 outside reset; also saturates.
- Undefined: neither port exists, no counter logic, and behaviour is otherwise identical.

Test Plan:
- No conflict: c1 store 0x11 to 0x10, c2 load 0x20 in the same cycle.
  - Required: both stalls 0, m_MemWrite_o1 = 1, m_MemRead_o2 = 1, c2_data_o = memory word 0x20.
- Write/read conflict: c1 store 0xAA to 0x08, c2 load 0x08, prio = 0.
  - Cycle 0: c2_stall_o = 1, m_MemRead_o2 = 0.
  - Cycle 1: c2 load proceeds and returns 0xAA; prio = 1.
- Persistent write/write conflict at 0x30 for 4 cycles.
  - Required: grants alternate c1, c2, c1, c2; stalls alternate; final memory word = value stored in the last granted write (c2's).
- Illegal access: c1 load from 0x06, then c2 store to 0x80 with MEM_BYTES = 128.
  - Required: no memory enables, no stalls; err_o goes 01, then 11, and holds.
- Reset mid-conflict: drop rst_i during a conflict cycle.
  - Required: immediately both stalls 1, enables 0, err_o = 0, prio = 0; after release, a conflict grants core1 first.
- DMEM_ARB_STATS_EN with CNT_W = 4: drive 20 consecutive conflict cycles.
  - Required: conflict_cnt_o saturates at 15; stall_cyc_o = 15.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Connects two CPU MEM stages to a shared dual-port data memory.
//               Same-word conflicts where at least one side writes are
//               serialized with round-robin priority. Misaligned and
//               out-of-range accesses are masked and flagged in sticky bits.
//               Define DMEM_ARB_STATS_EN to add saturating conflict and
//               stall-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_BYTES = 128
`ifdef DMEM_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       c1_addr_i,
  input  logic [31:0]       c1_data_i,
  input  logic              c1_MemRead_i,
  input  logic              c1_MemWrite_i,
  output logic [31:0]       c1_data_o,
  output logic              c1_stall_o,
  input  logic [31:0]       c2_addr_i,
  input  logic [31:0]       c2_data_i,
  input  logic              c2_MemRead_i,
  input  logic              c2_MemWrite_i,
  output logic [31:0]       c2_data_o,
  output logic              c2_stall_o,
  output logic [31:0]       m_addr_o1,
  output logic [31:0]       m_data_o1,
  output logic              m_MemRead_o1,
  output logic              m_MemWrite_o1,
  input  logic [31:0]       m_data_i1,
  output logic [31:0]       m_addr_o2,
  output logic [31:0]       m_data_o2,
  output logic              m_MemRead_o2,
  output logic              m_MemWrite_o2,
  input  logic [31:0]       m_data_i2,
  output logic [1:0]        err_o
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] conflict_cnt_o
  , output logic [CNT_W-1:0] stall_cyc_o
`endif
);

  // Highest legal word-aligned byte address.
  localparam logic [31:0] c_max_addr = 32'(MEM_BYTES - 4);

  logic       prio_q, prio_d;   // 0 = core1 favoured, 1 = core2 favoured
  logic [1:0] err_q,  err_d;

  logic w_c1_req, w_c2_req;
  logic w_c1_ill, w_c2_ill;
  logic w_c1_ok,  w_c2_ok;
  logic w_conflict;
  logic w_c1_stall, w_c2_stall;
  logic w_c1_go,  w_c2_go;

  // Data and address paths are pure pass-through.
  assign m_addr_o1 = c1_addr_i;
  assign m_data_o1 = c1_data_i;
  assign c1_data_o = m_data_i1;
  assign m_addr_o2 = c2_addr_i;
  assign m_data_o2 = c2_data_i;
  assign c2_data_o = m_data_i2;

  // Request decode, legality screening, conflict detection and grant.
  always_comb begin
    w_c1_req   = c1_MemRead_i | c1_MemWrite_i;
    w_c2_req   = c2_MemRead_i | c2_MemWrite_i;
    w_c1_ill   = w_c1_req & ((c1_addr_i[1:0] != 2'b00) | (c1_addr_i > c_max_addr));
    w_c2_ill   = w_c2_req & ((c2_addr_i[1:0] != 2'b00) | (c2_addr_i > c_max_addr));
    w_c1_ok    = w_c1_req & ~w_c1_ill;
    w_c2_ok    = w_c2_req & ~w_c2_ill;
    // Legality is resolved first, so an illegal access never conflicts.
    w_conflict = w_c1_ok & w_c2_ok & (c1_addr_i[31:2] == c2_addr_i[31:2])
               & (c1_MemWrite_i | c2_MemWrite_i);
    w_c1_stall = w_conflict & prio_q;
    w_c2_stall = w_conflict & ~prio_q;
    w_c1_go    = w_c1_ok & ~w_c1_stall;
    w_c2_go    = w_c2_ok & ~w_c2_stall;
    // Loser of a conflict becomes favoured for the next cycle.
    prio_d     = w_conflict ? ~prio_q : prio_q;
    err_d      = err_q | {w_c2_ill, w_c1_ill};
  end

  // While reset is held both cores stall and the memory sees no enables.
  // A request with both strobes set is treated as a store.
  always_comb begin
    c1_stall_o    = ~rst_i | w_c1_stall;
    c2_stall_o    = ~rst_i | w_c2_stall;
    m_MemRead_o1  = rst_i & w_c1_go & c1_MemRead_i & ~c1_MemWrite_i;
    m_MemWrite_o1 = rst_i & w_c1_go & c1_MemWrite_i;
    m_MemRead_o2  = rst_i & w_c2_go & c2_MemRead_i & ~c2_MemWrite_i;
    m_MemWrite_o2 = rst_i & w_c2_go & c2_MemWrite_i;
    err_o         = err_q;
  end

  // Priority and sticky error state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prio_q <= 1'b0;
      err_q  <= 2'b00;
    end else begin
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0] stall_cyc_q,    stall_cyc_d;

  // Saturating event counters; outside reset a stall only arises from a conflict.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cyc_d    = stall_cyc_q;
    if (w_conflict && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    if ((w_c1_stall | w_c2_stall) && (stall_cyc_q != '1))
      stall_cyc_d = stall_cyc_q + CNT_W'(1);
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conflict_cnt_q <= '0;
      stall_cyc_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cyc_q    <= stall_cyc_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign stall_cyc_o    = stall_cyc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               behavioural dual-port memory behind the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] c1_addr_i = '0, c1_data_i = '0;
  logic        c1_MemRead_i = 1'b0, c1_MemWrite_i = 1'b0;
  logic [31:0] c2_addr_i = '0, c2_data_i = '0;
  logic        c2_MemRead_i = 1'b0, c2_MemWrite_i = 1'b0;
  logic [31:0] c1_data_o, c2_data_o;
  logic        c1_stall_o, c2_stall_o;
  logic [31:0] m_addr_o1, m_data_o1, m_data_i1;
  logic [31:0] m_addr_o2, m_data_o2, m_data_i2;
  logic        m_MemRead_o1, m_MemWrite_o1, m_MemRead_o2, m_MemWrite_o2;
  logic [1:0]  err_o;
`ifdef DMEM_ARB_STATS_EN
  logic [3:0]  conflict_cnt_o, stall_cyc_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:31];

`ifdef DMEM_ARB_STATS_EN
  dmem_arbiter #(.MEM_BYTES(128), .CNT_W(4)) dut (
`else
  dmem_arbiter #(.MEM_BYTES(128)) dut (
`endif
    .clk_i(clk_i), .rst_i(rst_i),
    .c1_addr_i(c1_addr_i), .c1_data_i(c1_data_i),
    .c1_MemRead_i(c1_MemRead_i), .c1_MemWrite_i(c1_MemWrite_i),
    .c1_data_o(c1_data_o), .c1_stall_o(c1_stall_o),
    .c2_addr_i(c2_addr_i), .c2_data_i(c2_data_i),
    .c2_MemRead_i(c2_MemRead_i), .c2_MemWrite_i(c2_MemWrite_i),
    .c2_data_o(c2_data_o), .c2_stall_o(c2_stall_o),
    .m_addr_o1(m_addr_o1), .m_data_o1(m_data_o1),
    .m_MemRead_o1(m_MemRead_o1), .m_MemWrite_o1(m_MemWrite_o1),
    .m_data_i1(m_data_i1),
    .m_addr_o2(m_addr_o2), .m_data_o2(m_data_o2),
    .m_MemRead_o2(m_MemRead_o2), .m_MemWrite_o2(m_MemWrite_o2),
    .m_data_i2(m_data_i2),
    .err_o(err_o)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt_o(conflict_cnt_o), .stall_cyc_o(stall_cyc_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Behavioural dual-port memory: combinational read, write on rising edge.
  always @(posedge clk_i) begin
    if (m_MemWrite_o1) mem[m_addr_o1[6:2]] <= m_data_o1;
    if (m_MemWrite_o2) mem[m_addr_o2[6:2]] <= m_data_o2;
  end
  assign m_data_i1 = mem[m_addr_o1[6:2]];
  assign m_data_i2 = mem[m_addr_o2[6:2]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Apply one request per core, then let combinational outputs settle.
  task automatic drive(input logic [31:0] a1, input logic [31:0] d1, input logic r1, input logic w1,
                       input logic [31:0] a2, input logic [31:0] d2, input logic r2, input logic w2);
    c1_addr_i = a1; c1_data_i = d1; c1_MemRead_i = r1; c1_MemWrite_i = w1;
    c2_addr_i = a2; c2_data_i = d2; c2_MemRead_i = r2; c2_MemWrite_i = w2;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_stall1", {31'b0, c1_stall_o}, 32'd1);
    check("rst_stall2", {31'b0, c2_stall_o}, 32'd1);
    check("rst_en", {28'b0, m_MemRead_o1, m_MemWrite_o1, m_MemRead_o2, m_MemWrite_o2}, 32'h0);
    check("rst_err", {30'b0, err_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b1;
    next_cycle();

    // Seed word 0x20 from core2
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 32'hCAFE0020, 1'b0, 1'b1);
    check("seed_wr2", {31'b0, m_MemWrite_o2}, 32'd1);
    next_cycle();

    // No conflict: c1 store 0x11 to 0x10, c2 load 0x20
    drive(32'h10, 32'h11, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 1'b0);
    check("nc_stalls", {30'b0, c1_stall_o, c2_stall_o}, 32'h0);
    check("nc_wr1", {31'b0, m_MemWrite_o1}, 32'd1);
    check("nc_rd2", {31'b0, m_MemRead_o2}, 32'd1);
    check("nc_data2", c2_data_o, 32'hCAFE0020);
    next_cycle();

    // Write/read conflict at 0x08, prio 0: core2 stalls
    drive(32'h08, 32'hAA, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 1'b0);
    check("wr_c0_stall2", {31'b0, c2_stall_o}, 32'd1);
    check("wr_c0_stall1", {31'b0, c1_stall_o}, 32'd0);
    check("wr_c0_rd2", {31'b0, m_MemRead_o2}, 32'd0);
    check("wr_c0_wr1", {31'b0, m_MemWrite_o1}, 32'd1);
    next_cycle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h08, 32'h0, 1'b1, 1'b0);
    check("wr_c1_stall2", {31'b0, c2_stall_o}, 32'd0);
    check("wr_c1_rd2", {31'b0, m_MemRead_o2}, 32'd1);
    check("wr_c1_data2", c2_data_o, 32'hAA);
    next_cycle();

    // prio is now 1: core1 loses the next conflict
    drive(32'h08, 32'h0, 1'b1, 1'b0, 32'h08, 32'hBB, 1'b0, 1'b1);
    check("p1_stall1", {31'b0, c1_stall_o}, 32'd1);
    check("p1_rd1", {31'b0, m_MemRead_o1}, 32'd0);
    check("p1_wr2", {31'b0, m_MemWrite_o2}, 32'd1);
    next_cycle();
    drive(32'h08, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("p1_data1", c1_data_o, 32'hBB);
    next_cycle();

    // Persistent write/write conflict at 0x30: grants c1, c2, c1, c2
    for (int k = 0; k < 4; k++) begin
      drive(32'h30, 32'h100 + k, 1'b0, 1'b1, 32'h30, 32'h200 + k, 1'b0, 1'b1);
      check($sformatf("ww%0d_stall1", k), {31'b0, c1_stall_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("ww%0d_stall2", k), {31'b0, c2_stall_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ww%0d_wr", k), {30'b0, m_MemWrite_o1, m_MemWrite_o2},
            (k % 2 == 0) ? 32'h2 : 32'h1);
      next_cycle();
    end
    drive(32'h30, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ww_final", c1_data_o, 32'h203);
    next_cycle();

    // Boundary: 0x7C is the last legal word
    drive(32'h7C, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("legal_7c", {31'b0, m_MemRead_o1}, 32'd1);
    next_cycle();
    check("legal_7c_err", {30'b0, err_o}, 32'h0);

    // Illegal: c1 load from 0x06, then c2 store to 0x80
    drive(32'h06, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ill1_en", {30'b0, m_MemRead_o1, m_MemWrite_o1}, 32'h0);
    check("ill1_stall", {31'b0, c1_stall_o}, 32'd0);
    check("ill1_err_pre", {30'b0, err_o}, 32'h0);
    next_cycle();
    check("ill1_err", {30'b0, err_o}, 32'h1);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h80, 32'h55, 1'b0, 1'b1);
    check("ill2_en", {30'b0, m_MemRead_o2, m_MemWrite_o2}, 32'h0);
    check("ill2_stall", {31'b0, c2_stall_o}, 32'd0);
    next_cycle();
    check("ill2_err", {30'b0, err_o}, 32'h3);
    idle();
    next_cycle();
    check("ill_hold", {30'b0, err_o}, 32'h3);

    // Reset mid-conflict: first conflict moves prio to 1
    drive(32'h30, 32'h1, 1'b0, 1'b1, 32'h30, 32'h2, 1'b0, 1'b1);
    next_cycle();
    check("rc_pre_stall1", {31'b0, c1_stall_o}, 32'd1);
    #1; rst_i = 1'b0; #1;
    check("rc_stalls", {30'b0, c1_stall_o, c2_stall_o}, 32'h3);
    check("rc_en", {28'b0, m_MemRead_o1, m_MemWrite_o1, m_MemRead_o2, m_MemWrite_o2}, 32'h0);
    check("rc_err", {30'b0, err_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1; #1;
    check("rc_post_stall1", {31'b0, c1_stall_o}, 32'd0);
    check("rc_post_stall2", {31'b0, c2_stall_o}, 32'd1);
    check("rc_post_wr1", {31'b0, m_MemWrite_o1}, 32'd1);
    next_cycle();

`ifdef DMEM_ARB_STATS_EN
    // Saturating statistics over 20 conflict cycles
    @(negedge clk_i); rst_i = 1'b0; #1;
    check("st_rst_cnt", {28'b0, conflict_cnt_o}, 32'h0);
    check("st_rst_stall", {28'b0, stall_cyc_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b1;
    drive(32'h40, 32'h1, 1'b0, 1'b1, 32'h40, 32'h2, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) next_cycle();
    check("st_cnt_sat", {28'b0, conflict_cnt_o}, 32'hF);
    check("st_stall_sat", {28'b0, stall_cyc_o}, 32'hF);
`endif

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
